// File: rtl/mem_access_unit_pkg.sv
// Shared memory-access types: access width, exception mask bits and the
// address legality check used when a core request is accepted.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_access_t;

    typedef logic [1:0] mem_exception_mask_t;

    localparam mem_exception_mask_t MEM_EXCEPT_NONE         = 2'b00;
    localparam mem_exception_mask_t MEM_EXCEPT_MISALIGNED   = 2'b01;
    localparam mem_exception_mask_t MEM_EXCEPT_ILLEGAL_ADDR = 2'b10;

    // Both bits may be set together; the caller treats any nonzero mask as a fault.
    function automatic mem_exception_mask_t mem_check_access(
        input logic [31:0] addr,
        input mem_access_t access,
        input logic [3:0]  bank,
        input int          words
    );
        mem_exception_mask_t exc;
        exc = MEM_EXCEPT_NONE;
        if ((addr[31:28] != bank) || (int'({6'b0, addr[27:2]}) >= words))
            exc = exc | MEM_EXCEPT_ILLEGAL_ADDR;
        if (((access == MEM_HALF) && addr[0]) ||
            ((access == MEM_WORD) && (addr[1:0] != 2'b00)))
            exc = exc | MEM_EXCEPT_MISALIGNED;
        return exc;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bus of the memory access unit.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic                req;
    logic [31:0]         addr;
    logic                wr_ena;
    logic [31:0]         wr_data;
    mem_access_t         access;
    logic [31:0]         rd_data;
    logic                done;
    logic                busy;
    mem_exception_mask_t exception;

    modport master (
        output req, addr, wr_ena, wr_data, access,
        input  rd_data, done, busy, exception
    );

    modport slave (
        input  req, addr, wr_ena, wr_data, access,
        output rd_data, done, busy, exception
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: extracts a zero-extended byte/half/word from a RAM
// word and merges right-justified store data into the addressed lane.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_access_t access,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] lane_in,
    output logic [31:0] lane_out,
    output logic [31:0] merged
);

    always_comb begin
        lane_out = 32'h0;
        case (access)
            MEM_BYTE: lane_out = {24'h0, word_in[{offset, 3'b000} +: 8]};
            MEM_HALF: lane_out = {16'h0, word_in[{offset[1], 4'b0000} +: 16]};
            default:  lane_out = word_in;
        endcase
    end

    // Each byte of the merged word either keeps the RAM byte or takes store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       sel;
            logic [7:0] src;

            always_comb begin
                sel = 1'b1;
                src = lane_in[8*gi +: 8];
                case (access)
                    MEM_BYTE: begin
                        sel = (offset == 2'(gi));
                        src = lane_in[7:0];
                    end
                    MEM_HALF: begin
                        sel = (offset[1] == 1'(gi / 2));
                        src = lane_in[8*(gi % 2) +: 8];
                    end
                    default: ;
                endcase
            end

            assign merged[8*gi +: 8] = sel ? src : word_in[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns one core byte/half/word load or store into RAM
// cycles on a 1-cycle-latency single-port RAM, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [3:0] BANK      = 4'h1,
    parameter int         RAM_WORDS = 1024,
    localparam int        AW        = $clog2(RAM_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    mem_access_unit_if.slave    bus,
    output logic [AW-1:0]       ram_addr,
    output logic [31:0]         ram_wr_data,
    output logic                ram_wr_ena,
    input  logic [31:0]         ram_rd_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state_reg, state_next;
    logic [AW+1:0]       addr_reg;
    logic [31:0]         wr_data_reg;
    mem_access_t         access_reg;
    logic                wr_ena_reg;
    mem_exception_mask_t exc_reg;
    mem_exception_mask_t exc_now;
    logic [31:0]         lane_out;
    logic [31:0]         merged;
    logic                accept;

    assign exc_now = mem_check_access(bus.addr, bus.access, BANK, RAM_WORDS);
    assign accept  = (state_reg == S_IDLE) && bus.req;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.req) begin
                    if (exc_now != MEM_EXCEPT_NONE)  state_next = S_DONE;
                    else if (!bus.wr_ena)            state_next = S_RD;
                    else if (bus.access == MEM_WORD) state_next = S_WR;
                    else                             state_next = S_RD;
                end
            end
            // A store reaching RD is always sub-word, so it needs the merge cycle.
            S_RD:    state_next = wr_ena_reg ? S_MERGE : S_DONE;
            S_MERGE: state_next = S_DONE;
            S_WR:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            access_reg  <= MEM_BYTE;
            wr_ena_reg  <= 1'b0;
            exc_reg     <= MEM_EXCEPT_NONE;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg    <= bus.addr[AW+1:0];
                wr_data_reg <= bus.wr_data;
                access_reg  <= bus.access;
                wr_ena_reg  <= bus.wr_ena;
                exc_reg     <= exc_now;
            end
        end
    end

    mem_lane_align u_lane_align (
        .access   (access_reg),
        .offset   (addr_reg[1:0]),
        .word_in  (ram_rd_data),
        .lane_in  (wr_data_reg),
        .lane_out (lane_out),
        .merged   (merged)
    );

    // RAM controls decode straight from state so an async reset kills a write at once.
    assign ram_wr_ena  = (state_reg == S_WR) || (state_reg == S_MERGE);
    assign ram_wr_data = (state_reg == S_WR)    ? wr_data_reg :
                         (state_reg == S_MERGE) ? merged      : 32'h0;
    assign ram_addr    = ((state_reg == S_RD) || (state_reg == S_WR) || (state_reg == S_MERGE))
                         ? addr_reg[AW+1:2] : '0;

    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.exception = (state_reg == S_DONE) ? exc_reg : MEM_EXCEPT_NONE;
    assign bus.rd_data   = ((state_reg == S_DONE) && !wr_ena_reg && (exc_reg == MEM_EXCEPT_NONE))
                           ? lane_out : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// checked against a word-array reference model driven by shift/mask arithmetic.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    logic [9:0]  ram_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_ena;
    logic [31:0] ram_rd_data = 32'h0;

    mem_access_unit #(.BANK(4'h1), .RAM_WORDS(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_ena  (ram_wr_ena),
        .ram_rd_data (ram_rd_data)
    );

    // Synchronous RAM with one-cycle read latency, plus write bookkeeping.
    logic [31:0] tb_ram [0:1023] = '{default: 32'h0};
    int unsigned wr_count     = 0;
    logic [9:0]  last_wr_addr = 10'h0;
    always @(posedge clk) begin
        if (ram_wr_ena) begin
            tb_ram[ram_addr] <= ram_wr_data;
            wr_count         <= wr_count + 1;
            last_wr_addr     <= ram_addr;
        end
        ram_rd_data <= tb_ram[ram_addr];
    end

    logic [31:0] ref_mem [0:1023];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: decides exception, latency and load value, and updates ref_mem.
    task automatic model(input logic wr, input mem_access_t acc, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [1:0] exc,
                         output logic [31:0] rd);
        int unsigned idx;
        int          sh;
        logic [31:0] mask;
        idx = a[11:2];
        exc = 2'b00;
        if (a[31:28] != 4'h1 || a[27:2] >= 26'd1024) exc = exc | MEM_EXCEPT_ILLEGAL_ADDR;
        if ((acc == MEM_HALF && a[0]) || (acc == MEM_WORD && a[1:0] != 2'b00))
            exc = exc | MEM_EXCEPT_MISALIGNED;
        case (acc)
            MEM_BYTE: begin sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF; end
            MEM_HALF: begin sh = 16 * int'(a[1]);  mask = 32'h0000_FFFF; end
            default:  begin sh = 0;                mask = 32'hFFFF_FFFF; end
        endcase
        rd = 32'h0;
        if (exc != 2'b00) begin
            lat = 1;
        end else if (!wr) begin
            lat = 2;
            rd  = (ref_mem[idx] >> sh) & mask;
        end else begin
            lat = (acc == MEM_WORD) ? 2 : 3;
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((d & mask) << sh);
        end
    endtask

    task automatic txn(input string tag, input logic wr, input mem_access_t acc,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
        int          lat;
        logic [1:0]  exc;
        logic [31:0] rd;
        int          cyc;
        int unsigned wc0;
        int unsigned exp_wr;
        model(wr, acc, a, d, lat, exc, rd);
        exp_wr = (exc == 2'b00 && wr) ? 1 : 0;
        @(negedge clk);
        bus.req = 1'b1; bus.wr_ena = wr; bus.addr = a; bus.wr_data = d; bus.access = acc;
        wc0 = wr_count;
        @(posedge clk); #1;
        if (!hold) bus.req = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.req = 1'b0;
        check({tag, " latency"},   32'(cyc), 32'(lat));
        check({tag, " exception"}, 32'(bus.exception), 32'(exc));
        check({tag, " rd_data"},   bus.rd_data, rd);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {30'b0, bus.busy, bus.done}, 32'h0);
        check({tag, " writes"}, wr_count - wc0, exp_wr);
        if (exp_wr == 1) check({tag, " wr_addr"}, {22'b0, last_wr_addr}, {22'b0, a[11:2]});
        check({tag, " ram_word"}, tb_ram[a[11:2]], ref_mem[a[11:2]]);
        $display("txn %s wr=%0d acc=%0d addr=%h data=%h -> lat=%0d exc=%0d rd=%h",
                 tag, wr, acc, a, d, cyc, bus.exception, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] saved;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        bus.req = 1'b0; bus.wr_ena = 1'b0; bus.addr = 32'h0; bus.wr_data = 32'h0;
        bus.access = MEM_BYTE;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset done",      {31'b0, bus.done}, 32'h0);
        check("reset busy",      {31'b0, bus.busy}, 32'h0);
        check("reset exception", 32'(bus.exception), 32'h0);
        check("reset rd_data",   bus.rd_data, 32'h0);
        check("reset ram_wr",    {31'b0, ram_wr_ena}, 32'h0);
        check("reset ram_addr",  {22'b0, ram_addr}, 32'h0);
        @(negedge clk); rst = 1'b1;

        // Word store then load
        txn("wstore", 1'b1, MEM_WORD, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0);
        check("wstore word4", tb_ram[4], 32'hDEAD_BEEF);
        txn("wload", 1'b0, MEM_WORD, 32'h1000_0010, 32'h0, 1'b0);

        // Byte merge
        txn("preload", 1'b1, MEM_WORD, 32'h1000_0000, 32'h1122_3344, 1'b0);
        txn("bstore", 1'b1, MEM_BYTE, 32'h1000_0002, 32'hFFFF_FFAB, 1'b0);
        check("bstore word0", tb_ram[0], 32'h11AB_3344);
        txn("bload", 1'b0, MEM_BYTE, 32'h1000_0002, 32'h0, 1'b0);
        txn("hload", 1'b0, MEM_HALF, 32'h1000_0002, 32'h0, 1'b0);

        // Exceptions and address boundary
        txn("misalign", 1'b0, MEM_WORD, 32'h1000_0006, 32'h0, 1'b0);
        txn("badbank", 1'b1, MEM_HALF, 32'h2000_0000, 32'h1234_5678, 1'b0);
        txn("oor", 1'b0, MEM_WORD, 32'h1000_1000, 32'h0, 1'b0);
        txn("lastword", 1'b1, MEM_WORD, 32'h1000_0FFC, 32'hCAFE_F00D, 1'b0);

        // req held high for the whole sub-word store
        txn("hold", 1'b1, MEM_HALF, 32'h1000_0002, 32'h0000_5A5A, 1'b1);
        check("hold word0", tb_ram[0], 32'h5A5A_3344);

        // Reset during MERGE
        saved = tb_ram[0];
        @(negedge clk);
        bus.req = 1'b1; bus.wr_ena = 1'b1; bus.addr = 32'h1000_0001; bus.wr_data = 32'hCD;
        bus.access = MEM_BYTE;
        @(posedge clk); #1; bus.req = 1'b0;
        @(posedge clk); #1;
        check("merge ram_wr", {31'b0, ram_wr_ena}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rstmid ram_wr", {31'b0, ram_wr_ena}, 32'h0);
        check("rstmid busy",   {31'b0, bus.busy}, 32'h0);
        check("rstmid done",   {31'b0, bus.done}, 32'h0);
        @(posedge clk); #1;
        check("rstmid word0", tb_ram[0], saved);
        @(negedge clk); rst = 1'b1;
        $display("txn rstmid byte store aborted in MERGE, word0=%h", tb_ram[0]);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if (r == 0) a[31:28] = 4'h3;
            if (r == 1) a = 32'h1000_0000 | (32'($urandom_range(1024, 4000)) << 2);
            txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                mem_access_t'(2'($urandom_range(0, 2))), a, $urandom, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
